conv5x5_engine: RTL and testbench

Two-layer convolution engine for a 64×64 image of 13-bit signed fixed-point pixels. It fetches pixels from external image memory and computes Layer 0, a 5×5 convolution with zero padding, bias and ReLU. It writes Layer 0 to external result memory 0, reads it back, and writes Layer 1 (2×2 max-pool, stride 2, 32×32) to result memory 1. It sits between the host image ROM and the two result RAMs and is started by a ready/busy handshake.

---
 rtl/conv5x5_engine.sv | 144 ++++++++++++++
 tb/tb_conv5x5_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv5x5_engine.sv
// conv5x5_engine: 5x5 zero-padded conv with bias/ReLU into result RAM 0, then 2x2 max-pool into RAM 1.
module conv5x5_engine #(
   parameter logic [499:0] KERNEL = {240'b0, 20'h10000, 240'b0},
   parameter logic [19:0] BIAS = 20'h00000,
   parameter int SIDE_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   output logic        busy,
   output logic [11:0] iaddr,
   input  logic [12:0] idata,
   output logic        cwr,
   output logic [11:0] caddr_wr,
   output logic [12:0] cdata_wr,
   output logic        crd,
   output logic [11:0] caddr_rd,
   input  logic [12:0] cdata_rd,
   output logic        csel
);
   localparam int L = SIDE_LOG2;
   localparam int W = L + 2;
   typedef enum logic [2:0] {IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_WR, DONE} state_t;
   state_t state, state_nx;
   logic [2*L-1:0] p;
   logic [2*L-3:0] pi;
   logic [2:0] dy, dx, q;
   logic drain, pv, tap_ok, unused_ok;
   logic [19:0] pw;
   logic [19:0] w [25];
   logic [4:0] k;
   logic [W-1:0] ty, tx;
   logic signed [37:0] acc, prod, conv_sum;
   logic [12:0] mx, pool_max, conv_res;
   always_comb begin
      for (int t = 0; t < 25; t++) w[t] = KERNEL[20*t +: 20];
      k = 5'(dy) * 5'd5 + 5'(dx);
      ty = W'(p[2*L-1:L]) + W'(dy) - W'(2);
      tx = W'(p[L-1:0]) + W'(dx) - W'(2);
      tap_ok = ty[W-1:L] == 2'b0 && tx[W-1:L] == 2'b0;
      prod = pv ? {{25{idata[12]}}, idata} * {{18{pw[19]}}, pw} : '0;
      // pixel*weight carries 20 fraction bits, so bias is aligned by <<4 and rounded at bit 15
      conv_sum = acc + prod + {{14{BIAS[19]}}, BIAS, 4'b0} + 38'sd32768;
      conv_res = conv_sum[37] ? '0 : conv_sum[28:16];
      pool_max = (q == 3'd1 || $signed(cdata_rd) > $signed(mx)) ? cdata_rd : mx;
   end
   assign unused_ok = ^{conv_sum[36:29], conv_sum[15:0]};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = ready ? CONV_RD : IDLE;
         CONV_RD: state_nx = drain ? CONV_WR : CONV_RD;
         CONV_WR: state_nx = &p ? POOL_RD : CONV_RD;
         POOL_RD: state_nx = q == 3'd4 ? POOL_WR : POOL_RD;
         POOL_WR: state_nx = &pi ? DONE : POOL_RD;
         default: state_nx = IDLE;
      endcase
   end
   // reads run one cycle ahead of accumulation: pv/pw describe the tap whose pixel arrives now
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 1'b0;
         cwr <= 1'b0;
         crd <= 1'b0;
         csel <= 1'b0;
         iaddr <= '0;
         caddr_wr <= '0;
         caddr_rd <= '0;
         cdata_wr <= '0;
         p <= '0;
         pi <= '0;
         dy <= '0;
         dx <= '0;
         q <= '0;
         drain <= 1'b0;
         pv <= 1'b0;
         pw <= '0;
         acc <= '0;
         mx <= '0;
      end else begin
         case (state)
            IDLE: if (ready) begin
               busy <= 1'b1;
               p <= '0;
               pi <= '0;
               dy <= '0;
               dx <= '0;
               q <= '0;
               drain <= 1'b0;
               pv <= 1'b0;
               acc <= '0;
            end
            CONV_RD: begin
               acc <= acc + prod;
               pv <= ~drain & tap_ok;
               pw <= w[k];
               iaddr <= 12'({ty[L-1:0], tx[L-1:0]});
               dx <= dx == 3'd4 ? 3'd0 : dx + 3'd1;
               dy <= (dx == 3'd4 && dy != 3'd4) ? dy + 3'd1 : dy;
               drain <= dx == 3'd4 && dy == 3'd4;
               if (drain) begin
                  cwr <= 1'b1;
                  csel <= 1'b0;
                  caddr_wr <= 12'(p);
                  cdata_wr <= conv_res;
               end
            end
            CONV_WR: begin
               cwr <= 1'b0;
               p <= p + 1'b1;
               dy <= '0;
               dx <= '0;
               drain <= 1'b0;
               pv <= 1'b0;
               acc <= '0;
               q <= '0;
            end
            POOL_RD: begin
               crd <= q != 3'd4;
               caddr_rd <= 12'({pi[2*L-3:L-1], q[1], pi[L-2:0], q[0]});
               if (q != 3'd0) mx <= pool_max;
               q <= q + 3'd1;
               if (q == 3'd4) begin
                  cwr <= 1'b1;
                  csel <= 1'b1;
                  caddr_wr <= 12'(pi);
                  cdata_wr <= pool_max;
               end
            end
            POOL_WR: begin
               cwr <= 1'b0;
               csel <= 1'b0;
               pi <= pi + 1'b1;
               q <= '0;
            end
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_conv5x5_engine.sv
// tb_conv5x5_engine: scoreboard bench; one 64x64 instance plus 8x8 instances with varied kernels/bias.
module tb_conv5x5_engine;
   typedef struct {logic sel; logic [11:0] addr; logic [12:0] data;} wr_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ready = 1'b0;
   int sel = 1;
   logic [12:0] idata = '0;
   logic [12:0] cdata_rd = '0;
   logic busy_v [5], cwr_v [5], crd_v [5], csel_v [5];
   logic [11:0] iaddr_v [5], caddr_wr_v [5], caddr_rd_v [5];
   logic [12:0] cdata_wr_v [5];
   logic busy_a, cwr_a, crd_a, csel_a;
   logic [11:0] iaddr_a, caddr_wr_a, caddr_rd_a;
   logic [12:0] cdata_wr_a;
   logic [12:0] img [4096];
   logic [12:0] l0 [4096];
   logic [12:0] l1 [4096];
   logic [12:0] e0 [4096];
   wr_t sb [$];
   int n_cmp = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam logic [499:0] K = g == 2 ? {25{20'h10000}} :
                                   g == 4 ? {240'b0, 20'h08000, 240'b0} : {240'b0, 20'h10000, 240'b0};
      localparam logic [19:0] B = g == 3 ? 20'hF0000 : 20'h00000;
      conv5x5_engine #(.KERNEL(K), .BIAS(B), .SIDE_LOG2(g == 0 ? 6 : 3)) u_dut (
         .clk(clk), .reset(reset), .ready(ready && sel == g), .busy(busy_v[g]),
         .iaddr(iaddr_v[g]), .idata(idata), .cwr(cwr_v[g]), .caddr_wr(caddr_wr_v[g]),
         .cdata_wr(cdata_wr_v[g]), .crd(crd_v[g]), .caddr_rd(caddr_rd_v[g]),
         .cdata_rd(cdata_rd), .csel(csel_v[g]));
   end
   assign busy_a = busy_v[sel];
   assign cwr_a = cwr_v[sel];
   assign crd_a = crd_v[sel];
   assign csel_a = csel_v[sel];
   assign iaddr_a = iaddr_v[sel];
   assign caddr_wr_a = caddr_wr_v[sel];
   assign caddr_rd_a = caddr_rd_v[sel];
   assign cdata_wr_a = cdata_wr_v[sel];
   always @(negedge clk) begin
      idata <= img[iaddr_a];
      if (crd_a) cdata_rd <= csel_a ? l1[caddr_rd_a] : l0[caddr_rd_a];
   end
   always @(posedge clk) if (cwr_a) begin
      if (csel_a) l1[caddr_wr_a] <= cdata_wr_a;
      else l0[caddr_wr_a] <= cdata_wr_a;
   end
   always @(negedge clk) if (cwr_a) begin
      wr_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL write_unexpected: got csel=%0d addr=%0d data=%h, required no write", csel_a, caddr_wr_a, cdata_wr_a);
      end else begin
         e = sb.pop_front();
         if ({csel_a, caddr_wr_a, cdata_wr_a, crd_a} !== {e.sel, e.addr, e.data, 1'b0}) begin
            n_fail++;
            $display("FAIL write: got csel=%0d addr=%0d data=%h crd=%0d, required csel=%0d addr=%0d data=%h crd=0",
                     csel_a, caddr_wr_a, cdata_wr_a, crd_a, e.sel, e.addr, e.data);
         end
      end
   end
   function automatic int kw(input int g, input int t);
      return g == 2 ? 65536 : g == 4 ? (t == 12 ? 32768 : 0) : (t == 12 ? 65536 : 0);
   endfunction
   function automatic int kb(input int g);
      return g == 3 ? -65536 : 0;
   endfunction
   task automatic push_run(input int g, input int lg);
      int s;
      longint acc;
      logic [12:0] m, v;
      s = 1 << lg;
      for (int p = 0; p < s * s; p++) begin
         acc = 0;
         for (int t = 0; t < 25; t++) begin
            int y, x;
            y = p / s + t / 5 - 2;
            x = p % s + t % 5 - 2;
            if (y >= 0 && y < s && x >= 0 && x < s) acc += longint'($signed(img[y*s+x])) * longint'(kw(g, t));
         end
         acc += longint'(kb(g)) * 16 + 32768;
         e0[p] = acc < 0 ? 13'd0 : 13'(acc >>> 16);
         sb.push_back('{1'b0, 12'(p), e0[p]});
      end
      for (int i = 0; i < s / 2; i++)
         for (int j = 0; j < s / 2; j++) begin
            m = e0[2*i*s + 2*j];
            for (int d = 1; d < 4; d++) begin
               v = e0[(2*i + d/2)*s + 2*j + d%2];
               if ($signed(v) > $signed(m)) m = v;
            end
            sb.push_back('{1'b1, 12'(i*(s/2) + j), m});
         end
   endtask
   task automatic fill(input int mode, input logic [12:0] val);
      for (int i = 0; i < 4096; i++) img[i] = mode == 1 ? 13'(i) : val;
   endtask
   task automatic start_run(input int g);
      sel = g;
      @(negedge clk);
      ready = 1'b1;
      repeat (3) @(negedge clk);
      ready = 1'b0;
   endtask
   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy_a !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic test_reset;
      #2 reset = 1'b0;
      #1;
      for (int g = 0; g < 5; g++) begin
         n_cmp++;
         if ({busy_v[g], cwr_v[g], crd_v[g], csel_v[g], iaddr_v[g], caddr_wr_v[g], caddr_rd_v[g], cdata_wr_v[g]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got busy=%b cwr=%b crd=%b csel=%b iaddr=%h caddr_wr=%h caddr_rd=%h cdata_wr=%h, required all 0",
                     g, busy_v[g], cwr_v[g], crd_v[g], csel_v[g], iaddr_v[g], caddr_wr_v[g], caddr_rd_v[g], cdata_wr_v[g]);
         end
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic run_check(input int g, input string name);
      int n;
      push_run(g, 3);
      start_run(g);
      n_cmp++;
      if (busy_a !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: got %b, required 1", name, busy_a); end
      wait_idle(4000, n);
      n_cmp += 2;
      if (busy_a !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy_a, n); end
      if (sb.size() != 0) begin n_fail++; $display("FAIL %s_drain: got %0d writes pending, required 0", name, sb.size()); end
   endtask
   task automatic test_identity_const;
      int rises = 0;
      fill(0, 13'h0010);
      run_check(1, "ident_const");
      repeat (20) @(negedge clk) if (busy_a) rises++;
      n_cmp += 2;
      if (rises != 0) begin n_fail++; $display("FAIL ident_busy_once: got %0d busy cycles after done, required 0", rises); end
      if (l1[5] !== 13'h0010) begin n_fail++; $display("FAIL ident_l1: got %h, required 0010", l1[5]); end
   endtask
   task automatic test_identity_ramp;
      fill(1, '0);
      run_check(1, "ramp");
      n_cmp += 3;
      if (l0[27] !== 13'd27) begin n_fail++; $display("FAIL ramp_l0_27: got %0d, required 27", l0[27]); end
      if (l1[0] !== 13'd9) begin n_fail++; $display("FAIL ramp_l1_0: got %0d, required 9", l1[0]); end
      if (l1[15] !== 13'd63) begin n_fail++; $display("FAIL ramp_l1_15: got %0d, required 63", l1[15]); end
   endtask
   task automatic test_all_ones;
      fill(0, 13'h0010);
      run_check(2, "ones");
      n_cmp += 4;
      if (l0[0] !== 13'h090) begin n_fail++; $display("FAIL ones_corner: got %h, required 090", l0[0]); end
      if (l0[5] !== 13'h0F0) begin n_fail++; $display("FAIL ones_edge: got %h, required 0F0", l0[5]); end
      if (l0[9] !== 13'h100) begin n_fail++; $display("FAIL ones_1_1: got %h, required 100", l0[9]); end
      if (l0[18] !== 13'h190) begin n_fail++; $display("FAIL ones_interior: got %h, required 190", l0[18]); end
   endtask
   task automatic test_relu;
      fill(0, 13'h1FF0);
      run_check(1, "relu_neg");
      n_cmp++;
      if (l0[9] !== 13'h0) begin n_fail++; $display("FAIL relu_neg_l0: got %h, required 0", l0[9]); end
      fill(0, 13'h0008);
      run_check(3, "relu_bias");
      n_cmp++;
      if (l1[3] !== 13'h0) begin n_fail++; $display("FAIL relu_bias_l1: got %h, required 0", l1[3]); end
   endtask
   task automatic test_round;
      fill(0, 13'h0001);
      run_check(4, "round");
      n_cmp++;
      if (l0[0] !== 13'h0001) begin n_fail++; $display("FAIL round_l0: got %h, required 0001", l0[0]); end
   endtask
   task automatic test_addr_order_64;
      int n = 0;
      fill(1, '0);
      push_run(0, 6);
      start_run(0);
      while (sb.size() > 4920 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (sb.size() > 4920) begin n_fail++; $display("FAIL addr64_progress: got %0d pending, required <= 4920", sb.size()); end
      reset = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic test_reset_mid_run;
      fill(1, '0);
      push_run(1, 3);
      start_run(1);
      repeat (300) @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy_a, cwr_a, crd_a, csel_a, iaddr_a, caddr_wr_a, cdata_wr_a} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: got busy=%b cwr=%b crd=%b csel=%b iaddr=%h caddr_wr=%h cdata_wr=%h, required all 0",
                  busy_a, cwr_a, crd_a, csel_a, iaddr_a, caddr_wr_a, cdata_wr_a);
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      run_check(1, "midrun_rerun");
   endtask
   task automatic test_back_to_back;
      fill(0, 13'h0010);
      run_check(1, "b2b_first");
      fill(1, '0);
      run_check(1, "b2b_second");
   endtask
   initial begin
      test_reset;
      test_identity_const;
      test_identity_ramp;
      test_all_ones;
      test_relu;
      test_round;
      test_addr_order_64;
      test_reset_mid_run;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
